// File: rtl/fetch_line_sequencer_pkg.sv
// Shared fetch-line definitions: line geometry and the sequencer state encoding.
package fetch_line_sequencer_pkg;

    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned SLOTS      = 8;
    localparam int unsigned SLOT_SHIFT = 2;
    localparam int unsigned LINE_SHIFT = 5;
    localparam int unsigned LINE_W     = SLOTS * 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_line_sequencer_slot_mask.sv
// Slot-offset to valid-mask decode: slots at or above the fetch offset are valid.
// Purely combinational so the branch predictor can reuse it.
module fetch_line_sequencer_slot_mask
    import fetch_line_sequencer_pkg::*;
(
    input  logic [LINE_SHIFT-SLOT_SHIFT-1:0] slot,
    output logic [SLOTS-1:0]                 mask
);

    assign mask = {SLOTS{1'b1}} << slot;

endmodule

// File: rtl/fetch_line_sequencer.sv
// Fetch-line sequencer: issues one line request at a time, captures the returned
// line into a held bundle, presents it to the instruction buffer under
// back-pressure, and discards responses orphaned by a redirect.
module fetch_line_sequencer
    import fetch_line_sequencer_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              buf_full_i,
    output logic              ic_req_o,
    output logic [PC_W-1:0]   ic_addr_o,
    input  logic              ic_ack_i,
    input  logic              ic_rvld_i,
    input  logic [LINE_W-1:0] ic_rdata_i,
    output logic [LINE_W-1:0] inst_bundle_o,
    output logic [SLOTS-1:0]  inst_vld_o,
    output logic [PC_W-1:0]   bundle_pc_o,
    output logic              fetch_stall_o
);

    state_t            state;
    logic [PC_W-1:0]   fetch_pc;
    logic [LINE_W-1:0] bundle;
    logic [SLOTS-1:0]  mask;
    logic [PC_W-1:0]   bundle_pc;
    logic [SLOTS-1:0]  pc_mask;
    logic              drain_next;

    function automatic logic [PC_W-1:0] line_of(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(LINE_BYTES - 1);
    endfunction

    fetch_line_sequencer_slot_mask u_slot_mask (
        .slot (fetch_pc[LINE_SHIFT-1:SLOT_SHIFT]),
        .mask (pc_mask)
    );

    // A redirect leaves one response owed by the cache when it lands on an
    // accepted request or on a wait that has not yet seen its data.
    assign drain_next = (state == ST_REQ && ic_ack_i) ||
                        ((state == ST_WAIT || state == ST_DRAIN) && !ic_rvld_i);

    // Sequencer FSM with fetch PC, held bundle and registered request strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            bundle    <= '0;
            mask      <= '0;
            bundle_pc <= '0;
            ic_req_o  <= 1'b0;
        end else begin
            ic_req_o <= 1'b0;
            if (flush_i) begin
                fetch_pc <= redirect_pc_i;
                mask     <= '0;
                state    <= drain_next ? ST_DRAIN : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_REQ;
                        ic_req_o <= 1'b1;
                    end
                    ST_REQ: begin
                        if (ic_ack_i) begin
                            state <= ST_WAIT;
                        end else begin
                            ic_req_o <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (ic_rvld_i) begin
                            bundle    <= ic_rdata_i;
                            mask      <= pc_mask;
                            bundle_pc <= line_of(fetch_pc);
                            state     <= ST_OUT;
                        end
                    end
                    ST_OUT: begin
                        if (!buf_full_i) begin
                            fetch_pc <= line_of(fetch_pc) + PC_W'(LINE_BYTES);
                            state    <= ST_REQ;
                            ic_req_o <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (ic_rvld_i) begin
                            state    <= ST_REQ;
                            ic_req_o <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ic_addr_o     = line_of(fetch_pc);
    assign inst_bundle_o = bundle;
    assign bundle_pc_o   = bundle_pc;
    assign inst_vld_o    = (state == ST_OUT && !buf_full_i && !flush_i) ? mask : '0;
    assign fetch_stall_o = (state == ST_OUT) && buf_full_i && !flush_i;

    // Line data may only arrive while a request is outstanding.
    assert property (@(posedge clock) disable iff (!reset_n)
        ic_rvld_i |-> (state == ST_WAIT || state == ST_DRAIN));

    // A pending request keeps its address until accepted or redirected.
    assert property (@(posedge clock) disable iff (!reset_n)
        (ic_req_o && !ic_ack_i && !flush_i) |=> (ic_req_o && $stable(ic_addr_o)));

endmodule

// File: tb/tb_fetch_line_sequencer.sv
// Bench for fetch_line_sequencer: an i-cache responder, a transaction-level
// reference model checked every cycle, directed scenarios and a random phase.
module tb_fetch_line_sequencer;

    localparam int          PC_W   = 64;
    localparam logic [63:0] RST_PC = 64'h104;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         flush_i = 1'b0;
    logic [63:0]  redirect_pc_i = '0;
    logic         buf_full_i = 1'b0;
    logic         ic_req_o;
    logic [63:0]  ic_addr_o;
    logic         ic_ack_i = 1'b0;
    logic         ic_rvld_i = 1'b0;
    logic [255:0] ic_rdata_i = '0;
    logic [255:0] inst_bundle_o;
    logic [7:0]   inst_vld_o;
    logic [63:0]  bundle_pc_o;
    logic         fetch_stall_o;

    fetch_line_sequencer #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .buf_full_i    (buf_full_i),
        .ic_req_o      (ic_req_o),
        .ic_addr_o     (ic_addr_o),
        .ic_ack_i      (ic_ack_i),
        .ic_rvld_i     (ic_rvld_i),
        .ic_rdata_i    (ic_rdata_i),
        .inst_bundle_o (inst_bundle_o),
        .inst_vld_o    (inst_vld_o),
        .bundle_pc_o   (bundle_pc_o),
        .fetch_stall_o (fetch_stall_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lineof(input logic [63:0] pc);
        return {pc[63:5], 5'b0};
    endfunction

    // Each slot carries its own byte address in the low 24 bits and a per-response tag on top.
    function automatic logic [255:0] line_data(input logic [63:0] addr);
        logic [255:0] d;
        logic [7:0]   salt;
        salt = 8'($urandom);
        for (int k = 0; k < 8; k++) d[32*k +: 32] = {salt, addr[23:0] + 24'(4*k)};
        return d;
    endfunction

    // ---------------- i-cache responder ----------------
    bit           c_out = 0;
    int           c_cnt = 0;
    logic [255:0] c_data;
    int           ack_pct = 100;
    int           lat = 1;

    task automatic tick();
        @(posedge clock);
        #1;
        flush_i   = 1'b0;
        ic_rvld_i = 1'b0;
        ic_ack_i  = 1'b0;
        if (c_out) begin
            c_cnt--;
            if (c_cnt == 0) begin
                ic_rvld_i  = 1'b1;
                ic_rdata_i = c_data;
                c_out      = 0;
            end
        end else if (ic_req_o && int'($urandom_range(0, 99)) < ack_pct) begin
            ic_ack_i = 1'b1;
            c_out    = 1;
            c_cnt    = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
            c_data   = line_data(ic_addr_o);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    logic [63:0]  m_pc;
    bit           m_out, m_stale, m_pend, m_bubble;
    logic [255:0] m_data;
    logic [7:0]   m_mask;
    logic [63:0]  m_line;
    logic [7:0]   exp_vld;
    bit           hs, still;

    logic [63:0]  req_q[$];
    logic [7:0]   xv_q[$];
    logic [63:0]  xpc_q[$];
    logic [255:0] xd_q[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            m_pc = RST_PC; m_out = 0; m_stale = 0; m_pend = 0; m_bubble = 1;
            chk("rst_req", ic_req_o, 0);
            chk("rst_vld", inst_vld_o, 0);
            chk("rst_stall", fetch_stall_o, 0);
            chk("rst_bundle", inst_bundle_o, 0);
            chk("rst_bundle_pc", bundle_pc_o, 0);
            chk("rst_addr", ic_addr_o, 64'h100);
        end else begin
            exp_vld = (m_pend && !buf_full_i && !flush_i) ? m_mask : 8'h00;
            chk("inst_vld", inst_vld_o, exp_vld);
            chk("fetch_stall", fetch_stall_o, m_pend && buf_full_i && !flush_i);
            chk("ic_req", ic_req_o, !m_out && !m_pend && !m_bubble);
            if (ic_req_o) chk("ic_addr", ic_addr_o, lineof(m_pc));
            if (m_pend) begin
                chk("bundle", inst_bundle_o, m_data);
                chk("bundle_pc", bundle_pc_o, m_line);
            end
            if (inst_vld_o != 8'h00) begin
                xv_q.push_back(inst_vld_o);
                xpc_q.push_back(bundle_pc_o);
                xd_q.push_back(inst_bundle_o);
            end
            hs = ic_req_o && ic_ack_i;
            if (hs) req_q.push_back(ic_addr_o);
            if (flush_i) begin
                still    = hs || (m_out && !ic_rvld_i);
                m_pc     = redirect_pc_i;
                m_pend   = 0;
                m_out    = still;
                m_stale  = still;
                m_bubble = !still;
            end else begin
                m_bubble = 0;
                if (m_pend && !buf_full_i) begin
                    m_pend = 0;
                    m_pc   = lineof(m_pc) + 64'd32;
                end
                if (hs) begin
                    m_out = 1; m_stale = 0;
                end else if (ic_rvld_i && m_out) begin
                    m_out = 0;
                    if (!m_stale) begin
                        m_pend = 1;
                        m_data = ic_rdata_i;
                        m_mask = 8'hFF << m_pc[4:2];
                        m_line = lineof(m_pc);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_xfers(input int target, input int limit, input string name);
        int n = 0;
        while (xv_q.size() < target && n < limit) begin
            tick();
            n++;
        end
        chk(name, xv_q.size() >= target, 1);
    endtask

    task automatic quiesce();
        int n = 0;
        ack_pct    = 0;
        buf_full_i = 1'b0;
        do begin
            tick();
            n++;
        end while (!(ic_req_o && !c_out) && n < 60);
        chk("quiesce", ic_req_o && !c_out, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, r0, x0, idx;
        logic [63:0]  held;
        logic [7:0]   v;
        logic [255:0] d;

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // 1: first line from an unaligned reset PC, then a full sequential line
        wait_xfers(2, 60, "t1_done");
        if (req_q.size() >= 2 && xv_q.size() >= 2) begin
            chk("t1_addr0", req_q[0], 64'h100);
            chk("t1_vld0", xv_q[0], 8'hFE);
            chk("t1_addr1", req_q[1], 64'h120);
            chk("t1_vld1", xv_q[1], 8'hFF);
            chk("t1_pc1", xpc_q[1], 64'h120);
        end

        // 2: five cycles of back-pressure on a held bundle
        n = 0;
        do begin
            tick();
            buf_full_i = 1'b1;
            #1;
            n++;
        end while (!fetch_stall_o && n < 40);
        chk("t2_stall_seen", fetch_stall_o, 1);
        x0   = xv_q.size();
        held = bundle_pc_o;
        for (int i = 0; i < 4; i++) begin
            tick();
            buf_full_i = 1'b1;
            #1;
            chk("t2_stall", fetch_stall_o, 1);
            chk("t2_vld", inst_vld_o, 0);
            chk("t2_hold", bundle_pc_o, held);
        end
        tick();
        buf_full_i = 1'b0;
        @(negedge clock);
        #1;
        chk("t2_one", xv_q.size(), x0 + 1);
        repeat (5) tick();
        chk("t2_next", xv_q.size() >= x0 + 2, 1);
        if (xv_q.size() >= x0 + 2) begin
            chk("t2_pc0", xpc_q[x0], held);
            chk("t2_pc1", xpc_q[x0+1], held + 64'h20);
        end

        // 3: redirect while waiting, stale data arrives two cycles later
        quiesce();
        ack_pct = 100;
        lat     = 3;
        tick();
        chk("t3_ack", ic_ack_i && ic_req_o, 1);
        tick();
        flush_i       = 1'b1;
        redirect_pc_i = 64'h2008;
        r0 = req_q.size();
        x0 = xv_q.size();
        wait_xfers(x0 + 1, 40, "t3_done");
        if (xv_q.size() > x0 && req_q.size() > r0) begin
            chk("t3_addr", req_q[r0], 64'h2000);
            chk("t3_vld", xv_q[x0], 8'hFC);
            chk("t3_pc", xpc_q[x0], 64'h2000);
            chk("t3_slot0", xd_q[x0][23:0], 24'h002000);
            chk("t3_slot2", xd_q[x0][87:64], 24'h002008);
        end

        // 4: redirect in the same cycle the request is accepted
        quiesce();
        ack_pct = 100;
        lat     = 2;
        tick();
        chk("t4_ack", ic_ack_i && ic_req_o, 1);
        flush_i       = 1'b1;
        redirect_pc_i = 64'h3000;
        r0 = req_q.size();
        x0 = xv_q.size();
        tick();
        #1 chk("t4_drain_req0", ic_req_o, 0);
        tick();
        chk("t4_stale_rvld", ic_rvld_i, 1);
        #1 chk("t4_drain_req1", ic_req_o, 0);
        tick();
        chk("t4_req", ic_req_o, 1);
        chk("t4_addr", ic_addr_o, 64'h3000);
        wait_xfers(x0 + 1, 40, "t4_done");
        if (xv_q.size() > x0 && req_q.size() > r0 + 1) begin
            chk("t4_addr_q", req_q[r0+1], 64'h3000);
            chk("t4_pc", xpc_q[x0], 64'h3000);
            chk("t4_slot0", xd_q[x0][23:0], 24'h003000);
        end

        // 5: ten back-to-back lines from 0x0
        quiesce();
        flush_i       = 1'b1;
        redirect_pc_i = 64'h0;
        ack_pct       = 100;
        lat           = 1;
        r0 = req_q.size();
        x0 = xv_q.size();
        wait_xfers(x0 + 10, 200, "t5_done");
        if (xv_q.size() >= x0 + 10 && req_q.size() >= r0 + 10) begin
            idx = 0;
            for (int i = 0; i < 10; i++) begin
                chk("t5_addr", req_q[r0+i], 64'(32 * i));
                v = xv_q[x0+i];
                d = xd_q[x0+i];
                for (int k = 0; k < 8; k++) begin
                    if (v[k]) begin
                        chk("t5_slot", d[32*k +: 24], 24'(4 * idx));
                        idx++;
                    end
                end
            end
            chk("t5_count", idx, 80);
        end

        // 6: asynchronous reset in the middle of a wait, late data during reset
        lat = 3;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ic_ack_i && ic_req_o) && n < 40);
        chk("t6_ack", ic_ack_i && ic_req_o, 1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_req", ic_req_o, 0);
        chk("t6_vld", inst_vld_o, 0);
        chk("t6_stall", fetch_stall_o, 0);
        chk("t6_bundle", inst_bundle_o, 0);
        chk("t6_bundle_pc", bundle_pc_o, 0);
        chk("t6_addr", ic_addr_o, 64'h100);
        c_out = 0;
        @(posedge clock);
        #1;
        ic_rvld_i  = 1'b1;
        ic_rdata_i = '1;
        @(posedge clock);
        #1 ic_rvld_i = 1'b0;
        #1 reset_n = 1'b1;
        r0 = req_q.size();
        x0 = xv_q.size();
        wait_xfers(x0 + 1, 40, "t6_done");
        if (xv_q.size() > x0 && req_q.size() > r0) begin
            chk("t6_restart", req_q[r0], 64'h100);
            chk("t6_vld0", xv_q[x0], 8'hFE);
            chk("t6_slot1", xd_q[x0][55:32], 24'h000104);
        end

        // random traffic: back-pressure, redirects (some near the top of the address space)
        ack_pct = 60;
        lat     = 0;
        x0 = xv_q.size();
        for (int c = 0; c < 3000; c++) begin
            tick();
            buf_full_i = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 3) begin
                flush_i = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FF80 | 64'($urandom_range(0, 127));
                else
                    redirect_pc_i = {$urandom, $urandom};
            end
        end
        chk("rand_activity", xv_q.size() > x0 + 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
